// File: rtl/usb_pkt_tx.sv
// UTMI transmit packet assembler: handshake (PID only) or data (PID, payload, CRC16) packets.
// Optional TxReady watchdog enabled by defining USB_PKT_TX_WDOG_EN.
module usb_pkt_tx #(
   parameter int IFG_CYCLES  = 96,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_i,
   input  logic [3:0] pid_i,
   input  logic       is_data_i,
   input  logic [9:0] len_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic [7:0] DataOut_o,
   output logic       TxValid_o,
   input  logic       TxReady_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       underrun_o,
   output logic       timeout_o
);

   localparam int GAP_W = $clog2(IFG_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
   } state_t;

   state_t             state;
   logic               is_data_q;
   logic [9:0]         len_q;
   logic [9:0]         rem;
   logic [15:0]        crc;
   logic [GAP_W-1:0]   gap_cnt;
   logic               done_q;
   logic               underrun_q;
   logic               timeout_q;

   logic [15:0]        crc_next;
   logic               pull_due;
   logic [7:0]         pull_byte;
   logic               active;
   logic               wd_fire;

   // CRC-16/USB, reflected form: one byte, LSb first.
   function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   assign crc_next = crc16_upd(crc, DataOut_o);

   // A payload byte is due when the byte on the bus is accepted and another payload byte follows it.
   assign pull_due     = TxReady_i &&
                         ((state == S_PID  && is_data_q && len_q != 10'd0) ||
                          (state == S_DATA && rem != 10'd1));
   assign data_ready_o = pull_due && data_valid_i;
   assign pull_byte    = data_valid_i ? data_i : 8'h00;

   assign active = (state == S_PID) || (state == S_DATA) ||
                   (state == S_CRC_LO) || (state == S_CRC_HI);

`ifdef USB_PKT_TX_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = active && !TxReady_i && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wd_cnt <= '0;
      else if (!active || TxReady_i)
         wd_cnt <= '0;
      else if (!wd_fire)
         wd_cnt <= wd_cnt + WD_W'(1);
   end
`else
   // No watchdog: wait for TxReady indefinitely; timeout never asserts.
   assign wd_fire = (WDOG_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         is_data_q  <= 1'b0;
         len_q      <= '0;
         rem        <= '0;
         crc        <= 16'hFFFF;
         gap_cnt    <= '0;
         DataOut_o  <= 8'h00;
         TxValid_o  <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (wd_fire) begin
            TxValid_o <= 1'b0;
            timeout_q <= 1'b1;
            state     <= S_GAP;
         end else begin
            case (state)
               S_IDLE: begin
                  if (send_i) begin
                     is_data_q  <= is_data_i;
                     len_q      <= len_i;
                     DataOut_o  <= {~pid_i, pid_i};
                     TxValid_o  <= 1'b1;
                     crc        <= 16'hFFFF;
                     underrun_q <= 1'b0;
                     timeout_q  <= 1'b0;
                     state      <= S_PID;
                  end
               end
               S_PID: begin
                  if (TxReady_i) begin
                     if (!is_data_q) begin
                        TxValid_o <= 1'b0;
                        state     <= S_GAP;
                     end else if (len_q == 10'd0) begin
                        DataOut_o <= ~crc[7:0];
                        state     <= S_CRC_LO;
                     end else begin
                        DataOut_o <= pull_byte;
                        if (!data_valid_i) underrun_q <= 1'b1;
                        rem       <= len_q;
                        state     <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (TxReady_i) begin
                     crc <= crc_next;
                     rem <= rem - 10'd1;
                     if (rem == 10'd1) begin
                        DataOut_o <= ~crc_next[7:0];
                        state     <= S_CRC_LO;
                     end else begin
                        DataOut_o <= pull_byte;
                        if (!data_valid_i) underrun_q <= 1'b1;
                     end
                  end
               end
               S_CRC_LO: begin
                  if (TxReady_i) begin
                     DataOut_o <= ~crc[15:8];
                     state     <= S_CRC_HI;
                  end
               end
               S_CRC_HI: begin
                  if (TxReady_i) begin
                     TxValid_o <= 1'b0;
                     state     <= S_GAP;
                  end
               end
               S_GAP: begin
                  // gap_cnt is zero on every entry since it is cleared on the way out.
                  if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                     gap_cnt <= '0;
                     done_q  <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o     = (state != S_IDLE);
   assign done_o     = done_q;
   assign underrun_o = underrun_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_usb_pkt_tx.sv
// Table-driven bench for usb_pkt_tx: expected bytes queued per packet, popped on each accepted byte.
module tb_usb_pkt_tx;
   localparam int IFG = 96;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       send_i = 1'b0;
   logic [3:0] pid_i = '0;
   logic       is_data_i = 1'b0;
   logic [9:0] len_i = '0;
   logic [7:0] data_i = '0;
   logic       data_valid_i = 1'b0;
   logic       TxReady_i = 1'b0;
   logic       data_ready_o, TxValid_o, busy_o, done_o, underrun_o, timeout_o;
   logic [7:0] DataOut_o;

   usb_pkt_tx #(.IFG_CYCLES(IFG), .WDOG_CYCLES(4096)) dut (
      .clk(clk), .rst(rst), .send_i(send_i), .pid_i(pid_i), .is_data_i(is_data_i),
      .len_i(len_i), .data_i(data_i), .data_valid_i(data_valid_i),
      .data_ready_o(data_ready_o), .DataOut_o(DataOut_o), .TxValid_o(TxValid_o),
      .TxReady_i(TxReady_i), .busy_o(busy_o), .done_o(done_o),
      .underrun_o(underrun_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] pid;
      logic       is_data;
      int         len;
      logic [7:0] base;     // payload stream is base, base+1, ...
      int         und;      // payload slot with data_valid low, -1 none
      int         period;   // TxReady every period cycles
      logic       use_crc;  // 1: crc bytes below are known constants
      logic [7:0] crc_b0;
      logic [7:0] crc_b1;
      int         poke;     // pulse send_i when this many bytes accepted, -1 none
      int         rst_at;   // assert reset when this many bytes accepted, -1 none
   } rec_t;

   rec_t       tbl[9];
   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   task automatic run(input rec_t r);
      int total, acc, sp, pulls, cyc, exp_pulls;
      logic [15:0] c;
      logic [7:0]  b;
      logic        hit_und;
      bit          poked, last, got_done;
      exp_q.delete();
      c = 16'hFFFF;
      sp = 0;
      exp_q.push_back({~r.pid, r.pid});
      if (r.is_data) begin
         for (int s = 0; s < r.len; s++) begin
            if (s == r.und) b = 8'h00;
            else begin b = r.base + 8'(sp); sp++; end
            exp_q.push_back(b);
            c = crc_upd(c, b);
         end
         if (r.use_crc) begin
            exp_q.push_back(r.crc_b0);
            exp_q.push_back(r.crc_b1);
         end else begin
            c = ~c;
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
         end
      end
      total = exp_q.size();
      hit_und = r.is_data && r.und >= 0 && r.und < r.len;
      exp_pulls = r.is_data ? r.len - (hit_und ? 1 : 0) : 0;

      send_i = 1'b1; pid_i = r.pid; is_data_i = r.is_data; len_i = 10'(r.len);
      TxReady_i = 1'b0; data_valid_i = 1'b0;
      @(negedge clk);
      chk("pre_start_txvalid", TxValid_o, 0);
      @(posedge clk); #1;
      send_i = 1'b0; pid_i = 4'($urandom); len_i = 10'($urandom);
      acc = 0; sp = 0; pulls = 0; cyc = 0; poked = 0; last = 0;
      while (!last) begin
         if (cyc >= 20000) begin
            chk("byte_timeout", 32'(acc), 32'(total));
            TxReady_i = 1'b0;
            return;
         end
         TxReady_i    = TxValid_o && ((cyc % r.period) == r.period - 1);
         data_valid_i = (acc != r.und);
         data_i       = r.base + 8'(sp);
         send_i       = (acc == r.poke) && !poked;
         if (send_i) begin poked = 1; pid_i = 4'h5; len_i = 10'd0; end
         @(negedge clk);
         if (cyc == 0) begin
            chk("start_txvalid", TxValid_o, 1);
            chk("start_busy", busy_o, 1);
            chk("start_underrun_clr", underrun_o, 0);
            chk("start_timeout", timeout_o, 0);
         end
         if (acc == r.rst_at) begin
            rst = 1'b0;
            #1;
            chk("rst_txvalid", TxValid_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_ready", data_ready_o, 0);
            chk("rst_dataout", DataOut_o, 0);
            TxReady_i = 1'b0; data_valid_i = 1'b0; send_i = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("post_rst_txvalid", TxValid_o, 0);
            end
            @(posedge clk); #1;
            return;
         end
         if (data_ready_o) begin pulls++; sp++; end
         if (TxValid_o && TxReady_i) begin
            chk($sformatf("byte%0d", acc), DataOut_o, exp_q.pop_front());
            acc++;
            if (acc == total) last = 1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      TxReady_i = 1'b0; send_i = 1'b0; data_valid_i = 1'b0;
      chk("pulls", 32'(pulls), 32'(exp_pulls));
      got_done = 0;
      for (int k = 1; k <= IFG + 5 && !got_done; k++) begin
         @(negedge clk);
         if (k == 1) chk("txvalid_fall", TxValid_o, 0);
         if (k == IFG) chk("gap_busy", busy_o, 1);
         if (done_o) begin
            got_done = 1;
            chk("done_time", 32'(k), 32'(IFG + 1));
            chk("done_idle", busy_o, 0);
         end
      end
      if (!got_done) chk("done_seen", 0, 1);
      @(negedge clk);
      chk("done_pulse", done_o, 0);
      chk("underrun", underrun_o, {31'd0, hit_und});
      chk("timeout", timeout_o, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = '{4'h2, 1'b0, 0,  8'h00, -1, 1, 1'b0, 8'h00, 8'h00, -1, -1}; // ACK
      tbl[1] = '{4'h3, 1'b1, 9,  8'h31, -1, 4, 1'b1, 8'hC8, 8'hB4,  3, -1}; // DATA0 "123456789", ignored send
      tbl[2] = '{4'hB, 1'b1, 0,  8'h00, -1, 2, 1'b1, 8'h00, 8'h00, -1, -1}; // zero-length DATA1
      tbl[3] = '{4'h3, 1'b1, 3,  8'hA0,  1, 1, 1'b0, 8'h00, 8'h00, -1, -1}; // underrun mid payload
      tbl[4] = '{4'h3, 1'b1, 9,  8'h40, -1, 2, 1'b0, 8'h00, 8'h00, -1,  4}; // reset mid DATA
      tbl[5] = '{4'hB, 1'b1, 16, 8'h10, -1, 1, 1'b0, 8'h00, 8'h00, -1, -1}; // back-to-back TxReady
      tbl[6] = '{4'hA, 1'b0, 0,  8'h00, -1, 3, 1'b0, 8'h00, 8'h00, -1, -1}; // NAK
      tbl[7] = '{4'h3, 1'b1, 1,  8'h55,  0, 2, 1'b0, 8'h00, 8'h00, -1, -1}; // underrun on first byte
      tbl[8] = '{4'h3, 1'b1, 9,  8'h31, -1, 1, 1'b1, 8'hC8, 8'hB4, -1, -1}; // DATA0 at full rate

      repeat (2) @(negedge clk);
      chk("reset_dataout", DataOut_o, 0);
      chk("reset_txvalid", TxValid_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_underrun", underrun_o, 0);
      chk("reset_timeout", timeout_o, 0);
      chk("reset_ready", data_ready_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run(tbl[i]);

      // send_i while in the gap is ignored: no new packet starts.
      send_i = 1'b1; pid_i = 4'h2; is_data_i = 1'b0; len_i = '0;
      @(posedge clk); #1;
      send_i = 1'b0; TxReady_i = 1'b1;
      @(posedge clk); #1;
      TxReady_i = 1'b0;
      send_i = 1'b1; pid_i = 4'h3;
      @(posedge clk); #1;
      send_i = 1'b0;
      @(negedge clk);
      chk("gap_send_txvalid", TxValid_o, 0);
      chk("gap_send_busy", busy_o, 1);
      repeat (IFG + 4) @(posedge clk);
      @(negedge clk);
      chk("gap_send_idle", busy_o, 0);
      chk("gap_send_no_tx", TxValid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
